snn_frame_sequencer: RTL
========================

# snn_frame_sequencer

Controller between the JTAG chunk interface and the spiking-network core on the MKR Vidor 4000 fabric. Collects fixed-width data chunks announced by a PROGRESS level into a frame buffer and validates the chunk count when FINISH rises. Streams the frame to the SNN core one pixel per handshake, starts the core, and latches its classification result. Sits in the user-design area of the top level, clocked by the 120 MHz system clock.

## Interface
- CHUNK_W, 30, bits per JTAG chunk
- N_CHUNKS, 27, chunks per frame; buffer is CHUNK_W*N_CHUNKS bits
- N_PIXELS, 784, pixels streamed to the core; must be ≤ CHUNK_W*N_CHUNKS
- CLASS_W, 4, width of the classification result

- iCLK  in  1  system clock, 120 MHz; all logic on its rising edge
- iRESETn  in  1  asynchronous, active-low reset
- iDATA  in  CHUNK_W  chunk payload; stable while iPROGRESS is high
- iPROGRESS  in  1  level; each 0→1 edge announces one new chunk
- iFINISH  in  1  level; a 0→1 edge ends the frame
- oPIX_VALID  out  1  pixel beat valid
- oPIX_DATA  out  1  pixel bit, buffer[oPIX_INDEX]
- oPIX_INDEX  out  10  pixel index, 0..N_PIXELS-1
- oPIX_LAST  out  1  high on the beat with index N_PIXELS-1
- iPIX_READY  in  1  core accepts the beat
- oSNN_START  out  1  one-cycle start pulse to the core
- iSNN_DONE  in  1  core finished
- iSNN_CLASS  in  CLASS_W  core result; valid while iSNN_DONE is high
- oRESULT  out  CLASS_W  latched result
- oRESULT_VALID  out  1  oRESULT holds a fresh result
- oBUSY  out  1  high in STREAM or WAIT_SNN
- oERR  out  1  sticky frame error
- oCHUNK_CNT  out  5  chunks accepted in the current frame

## Operation
- iPROGRESS and iFINISH are synchronous to iCLK. Each is registered once. An edge is defined as the input high now and the registered copy low.
- State machine has three states: LOAD, STREAM and WAIT_SNN. Reset enters LOAD.
- LOAD, PROGRESS edge, with oCHUNK_CNT < N_CHUNKS:
  - write iDATA into buffer bits [cnt*CHUNK_W +: CHUNK_W], then increment cnt.
  - If cnt was 0, also clear oERR and oRESULT_VALID.
- LOAD, PROGRESS edge, with cnt = N_CHUNKS: drop the chunk and set oERR. cnt saturates.
- LOAD, FINISH edge:
  - cnt = 0: ignore the edge.
  - 0 < cnt ≠ N_CHUNKS: set oERR, clear cnt, stay in LOAD; no start is issued.
  - cnt = N_CHUNKS: clear cnt and go to STREAM with the pixel index at 0.
- Same-cycle PROGRESS and FINISH edges in LOAD: capture the chunk first, then evaluate FINISH against the updated count.
- STREAM:
  - oPIX_VALID is high and oPIX_DATA = buffer[index].
  - On each cycle with oPIX_VALID & iPIX_READY, increment the index.
  - The beat with oPIX_LAST moves to WAIT_SNN.
  - The beat is held stable while iPIX_READY is low.
- WAIT_SNN:
  - oSNN_START is high only on the first cycle. iSNN_DONE is ignored on that cycle.
  - On a later cycle with iSNN_DONE: oRESULT ← iSNN_CLASS, oRESULT_VALID ← 1, return to LOAD.
- PROGRESS or FINISH edges in STREAM or WAIT_SNN: the edge is ignored and oERR is set. The buffer is untouched.
- oBUSY = (state ≠ LOAD).
- Buffer bits at or above N_PIXELS are stored but never streamed.

## Timing
- Reset values: oPIX_VALID, oPIX_DATA, oPIX_INDEX, oPIX_LAST, oSNN_START, oRESULT, oRESULT_VALID, oBUSY, oERR and oCHUNK_CNT are all 0. Buffer contents are not reset.
- Reset asserted mid-operation aborts immediately to LOAD with the reset values above. The edge-detect registers reset to 0, so an input already high at reset release counts as an edge on the first clock.
- A chunk is written on the clock edge where iPROGRESS is first sampled high. oCHUNK_CNT updates on the same edge.
- FINISH edge at clock T: oPIX_VALID is high from T+1.
- With iPIX_READY held high, the last beat transfers at T+N_PIXELS, oSNN_START pulses at T+N_PIXELS+1, and the earliest accepted iSNN_DONE is at T+N_PIXELS+2.
- oRESULT and oRESULT_VALID update on the clock after iSNN_DONE is sampled. The FSM is in LOAD on that same clock.
- Throughput: one pixel per cycle. No bubbles between beats while iPIX_READY is high.

## Test plan
- 27 chunks with chunk k = k replicated, then FINISH, iPIX_READY=1, iSNN_DONE 3 cycles after start with class 7:
  - 784 beats with index 0..783; bit n equals bit (n mod 30) of chunk n/30.
  - oPIX_LAST only on index 783.
  - oSNN_START pulses at T+785.
  - oRESULT=7 and oRESULT_VALID=1; oERR=0.
- iPIX_READY toggled 1-0 every cycle: beats hold while not ready; the total is still 784 transfers; oSNN_START comes after the last.
- 26 chunks then FINISH: oERR=1, oCHUNK_CNT=0, no oPIX_VALID, no oSNN_START. The next correct 27-chunk frame clears oERR on its first chunk and completes.
- 28 PROGRESS edges then FINISH: the 28th chunk is dropped (buffer unchanged), oERR=1, oCHUNK_CNT stays at 27, and the frame still streams.
- A PROGRESS edge during STREAM sets oERR with the beat stream unaffected. FINISH with cnt=0 has no effect.
- iRESETn pulled low at beat 400: all outputs 0 asynchronously; after release, a fresh 27-chunk frame streams from index 0.

Source files
------------

// File: rtl/snn_frame_sequencer.sv
// Frame sequencer between the JTAG chunk port and the SNN core: gathers chunks
// into a frame buffer, streams it one pixel per handshake, then latches the core's class.
module snn_frame_sequencer #(
  parameter int CHUNK_W  = 30,
  parameter int N_CHUNKS = 27,
  parameter int N_PIXELS = 784,
  parameter int CLASS_W  = 4
) (
  input  logic               iCLK,
  input  logic               iRESETn,
  input  logic [CHUNK_W-1:0] iDATA,
  input  logic               iPROGRESS,
  input  logic               iFINISH,
  output logic               oPIX_VALID,
  output logic               oPIX_DATA,
  output logic [9:0]         oPIX_INDEX,
  output logic               oPIX_LAST,
  input  logic               iPIX_READY,
  output logic               oSNN_START,
  input  logic               iSNN_DONE,
  input  logic [CLASS_W-1:0] iSNN_CLASS,
  output logic [CLASS_W-1:0] oRESULT,
  output logic               oRESULT_VALID,
  output logic               oBUSY,
  output logic               oERR,
  output logic [4:0]         oCHUNK_CNT
);

  localparam int         BUF_W    = CHUNK_W * N_CHUNKS;
  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [4:0] CNT_FULL = 5'(N_CHUNKS);
  localparam logic [9:0] IDX_LAST = 10'(N_PIXELS - 1);

  logic [1:0]         state_q, state_d;
  logic               prog_q, fin_q;
  logic               prog_edge_s, fin_edge_s;
  logic [4:0]         cnt_q, cnt_d;
  logic [9:0]         idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               data_q, data_d;
  logic               last_q, last_d;
  logic               start_q, start_d;
  logic [CLASS_W-1:0] result_q, result_d;
  logic               rv_q, rv_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [BUF_W-1:0]   buf_q, buf_d;

  assign prog_edge_s = iPROGRESS & ~prog_q;
  assign fin_edge_s  = iFINISH & ~fin_q;

  // Next-state logic: the chunk capture is evaluated before FINISH so a same-cycle
  // last chunk counts toward the frame.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    start_d  = 1'b0;
    result_d = result_q;
    rv_d     = rv_q;
    err_d    = err_q;
    buf_d    = buf_q;
    case (state_q)
      S_LOAD: begin
        if (prog_edge_s) begin
          if (cnt_q < CNT_FULL) begin
            buf_d[int'(cnt_q)*CHUNK_W +: CHUNK_W] = iDATA;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd0) begin
              err_d = 1'b0;
              rv_d  = 1'b0;
            end else begin
              err_d = err_q;
            end
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q;
        end
        if (fin_edge_s) begin
          if (cnt_d == CNT_FULL) begin
            cnt_d   = 5'd0;
            state_d = S_STREAM;
            idx_d   = 10'd0;
            valid_d = 1'b1;
            last_d  = (IDX_LAST == 10'd0);
          end else if (cnt_d != 5'd0) begin
            cnt_d = 5'd0;
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_STREAM: begin
        if (prog_edge_s | fin_edge_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (iPIX_READY) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_WAIT;
            valid_d = 1'b0;
            last_d  = 1'b0;
            start_d = 1'b1;
          end else begin
            idx_d  = idx_q + 10'd1;
            last_d = ((idx_q + 10'd1) == IDX_LAST);
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (prog_edge_s | fin_edge_s) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        // Done is not trusted during the start cycle itself.
        if (!start_q && iSNN_DONE) begin
          result_d = iSNN_CLASS;
          rv_d     = 1'b1;
          state_d  = S_LOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_LOAD;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Output data and busy are precomputed so every port comes straight from a flop.
  always_comb begin
    data_d = valid_d & buf_d[idx_d];
    busy_d = (state_d != S_LOAD);
  end

  // Control and output registers.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state_q  <= S_LOAD;
      prog_q   <= 1'b0;
      fin_q    <= 1'b0;
      cnt_q    <= 5'd0;
      idx_q    <= 10'd0;
      valid_q  <= 1'b0;
      data_q   <= 1'b0;
      last_q   <= 1'b0;
      start_q  <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prog_q   <= iPROGRESS;
      fin_q    <= iFINISH;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      start_q  <= start_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Frame buffer keeps its contents across reset.
  always_ff @(posedge iCLK) begin
    buf_q <= buf_d;
  end

  assign oPIX_VALID    = valid_q;
  assign oPIX_DATA     = data_q;
  assign oPIX_INDEX    = idx_q;
  assign oPIX_LAST     = last_q;
  assign oSNN_START    = start_q;
  assign oRESULT       = result_q;
  assign oRESULT_VALID = rv_q;
  assign oBUSY         = busy_q;
  assign oERR          = err_q;
  assign oCHUNK_CNT    = cnt_q;

endmodule
